// File: rtl/pw_trigger_seq.sv
// Match-triggered pulse train generator: up to pNUM_TRIGGER_PULSES delayed pulses
// plus an independent one-cycle capture strobe, all timed from the accepting match.
module pw_trigger_seq #(
    parameter int pNUM_TRIGGER_PULSES  = 8,
    parameter int pNUM_TRIGGER_WIDTH   = 4,
    parameter int pDELAY_WIDTH         = 24,
    parameter int pCAPTURE_DELAY_WIDTH = 18
) (
    input  logic                                        fe_clk,
    input  logic                                        reset_n,
    input  logic                                        I_arm,
    input  logic                                        I_trigger_enable,
    input  logic                                        I_match,
    input  logic [pNUM_TRIGGER_WIDTH-1:0]               I_num_triggers,
    input  logic [pDELAY_WIDTH*pNUM_TRIGGER_PULSES-1:0] I_trigger_delay,
    input  logic [pDELAY_WIDTH*pNUM_TRIGGER_PULSES-1:0] I_trigger_width,
    input  logic [pCAPTURE_DELAY_WIDTH-1:0]             I_capture_delay,
    output logic                                        O_trigger,
    output logic                                        O_capture_enable_pulse,
    output logic                                        O_busy,
    output logic [pNUM_TRIGGER_WIDTH-1:0]               O_pulse_index
);
    localparam int NP = pNUM_TRIGGER_PULSES;
    localparam int NW = pNUM_TRIGGER_WIDTH;
    localparam int DW = pDELAY_WIDTH;
    localparam int CW = pCAPTURE_DELAY_WIDTH;
    localparam logic [NW-1:0] MAX_N = NW'(NP);

    typedef enum logic [1:0] {IDLE, DELAY, PULSE} state_t;

    state_t             state, state_nx;
    logic [DW-1:0]      cnt, cnt_nx;
    logic [NW-1:0]      idx, idx_nx, n_eff, n_eff_nx, idx_inc;
    logic [DW*NP-1:0]   sh_delay, sh_delay_nx, sh_width, sh_width_nx;
    logic [CW-1:0]      cap_cnt, cap_cnt_nx;
    logic               cap_act, cap_act_nx, cap_pulse_nx, trig_nx;
    logic               accept, abort;

    function automatic logic [DW-1:0] field(input logic [DW*NP-1:0] v, input logic [NW-1:0] k);
        return v[int'(k)*DW +: DW];
    endfunction

    function automatic logic [DW-1:0] dec_sat(input logic [DW-1:0] v);
        return (v == '0) ? '0 : v - 1'b1;
    endfunction

    assign O_busy        = (state != IDLE) | cap_act | O_capture_enable_pulse;
    assign O_pulse_index = idx;
    assign accept        = I_match & I_arm & I_trigger_enable & ~O_busy;
    assign abort         = O_busy & ~(I_arm & I_trigger_enable);
    assign idx_inc       = idx + 1'b1;

    always_comb begin
        state_nx     = state;
        cnt_nx       = cnt;
        idx_nx       = idx;
        n_eff_nx     = n_eff;
        sh_delay_nx  = sh_delay;
        sh_width_nx  = sh_width;
        cap_cnt_nx   = cap_cnt;
        cap_act_nx   = cap_act;
        cap_pulse_nx = 1'b0;
        trig_nx      = 1'b0;
        if (abort) begin
            state_nx   = IDLE;
            cnt_nx     = '0;
            idx_nx     = '0;
            cap_cnt_nx = '0;
            cap_act_nx = 1'b0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    sh_delay_nx = I_trigger_delay;
                    sh_width_nx = I_trigger_width;
                    idx_nx      = '0;
                    if (I_num_triggers == '0)        n_eff_nx = NW'(1);
                    else if (I_num_triggers > MAX_N) n_eff_nx = MAX_N;
                    else                             n_eff_nx = I_num_triggers;
                    // A zero first delay rises on the very next cycle, so DELAY is skipped.
                    if (I_trigger_delay[DW-1:0] == '0) begin
                        state_nx = PULSE;
                        cnt_nx   = dec_sat(I_trigger_width[DW-1:0]);
                        trig_nx  = 1'b1;
                    end else begin
                        state_nx = DELAY;
                        cnt_nx   = I_trigger_delay[DW-1:0] - 1'b1;
                    end
                end
                DELAY: if (cnt == '0) begin
                    state_nx = PULSE;
                    cnt_nx   = dec_sat(field(sh_width, idx));
                    trig_nx  = 1'b1;
                end else begin
                    cnt_nx = cnt - 1'b1;
                end
                PULSE: if (cnt != '0) begin
                    cnt_nx  = cnt - 1'b1;
                    trig_nx = 1'b1;
                end else if (idx_inc < n_eff) begin
                    // Later pulses always keep at least one low cycle after the previous one.
                    state_nx = DELAY;
                    idx_nx   = idx_inc;
                    cnt_nx   = dec_sat(field(sh_delay, idx_inc));
                end else begin
                    state_nx = IDLE;
                    idx_nx   = '0;
                end
                default: state_nx = IDLE;
            endcase
            if (accept) begin
                if (I_capture_delay == '0) begin
                    cap_pulse_nx = 1'b1;
                end else begin
                    cap_act_nx = 1'b1;
                    cap_cnt_nx = I_capture_delay - 1'b1;
                end
            end else if (cap_act) begin
                if (cap_cnt == '0) begin
                    cap_pulse_nx = 1'b1;
                    cap_act_nx   = 1'b0;
                end else begin
                    cap_cnt_nx = cap_cnt - 1'b1;
                end
            end
        end
    end

    always_ff @(posedge fe_clk or negedge reset_n) begin
        if (!reset_n) begin
            state                  <= IDLE;
            cnt                    <= '0;
            idx                    <= '0;
            n_eff                  <= '0;
            sh_delay               <= '0;
            sh_width               <= '0;
            cap_cnt                <= '0;
            cap_act                <= 1'b0;
            O_trigger              <= 1'b0;
            O_capture_enable_pulse <= 1'b0;
        end else begin
            state                  <= state_nx;
            cnt                    <= cnt_nx;
            idx                    <= idx_nx;
            n_eff                  <= n_eff_nx;
            sh_delay               <= sh_delay_nx;
            sh_width               <= sh_width_nx;
            cap_cnt                <= cap_cnt_nx;
            cap_act                <= cap_act_nx;
            O_trigger              <= trig_nx;
            O_capture_enable_pulse <= cap_pulse_nx;
        end
    end
endmodule
